// File: rtl/lfsr_hs_dualrail.sv
// Maximal-length LFSR stepped once per four-phase req/ack transaction.
// Each word is presented on dual rails, with a return to spacer between transactions.
module lfsr_hs_dualrail #(
    parameter int                 WIDTH       = 3,
    parameter int                 MODE        = 0,
    parameter logic [WIDTH-1:0]   TAPS        = 3'b110,
    parameter logic [WIDTH-1:0]   GPOLY       = 3'b011,
    parameter logic [WIDTH-1:0]   SEED        = 3'b001,
    parameter int                 SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    output logic             ack,
    output logic [WIDTH-1:0] data0,
    output logic [WIDTH-1:0] data1,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             wrap
);

    // state | meaning
    // IDLE  | spacer on rails, ack low; waits for req_s and accepts load
    // VALID | word on rails, ack rises on the next edge
    // HOLD  | word and ack held until req_s falls
    // RTZ   | rails back at spacer, ack falls on the next edge
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] VALID = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] RTZ   = 2'd3;

    logic [1:0]             fsm;
    logic [SYNC_STAGES-1:0] sync;
    logic                   req_s;
    logic [WIDTH-1:0]       state;
    logic [WIDTH-1:0]       start;
    logic [WIDTH-1:0]       fib_next;
    logic [WIDTH-1:0]       gal_next;
    logic [WIDTH-1:0]       raw_next;
    logic [WIDTH-1:0]       nxt;
    logic [WIDTH-1:0]       seed_g;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync[0] <= req;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    assign req_s = sync[SYNC_STAGES-1];

    // A zero state would lock the register up, so it is replaced by SEED.
    always_comb begin
        fib_next = {state[WIDTH-2:0], ^(state & TAPS)};
        gal_next = {state[WIDTH-2:0], 1'b0} ^ ({WIDTH{state[WIDTH-1]}} & GPOLY);
        raw_next = (MODE != 0) ? gal_next : fib_next;
        nxt      = (raw_next == '0) ? SEED : raw_next;
        seed_g   = (seed_in == '0) ? SEED : seed_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm   <= IDLE;
            state <= SEED;
            start <= SEED;
            ack   <= 1'b0;
            data0 <= '0;
            data1 <= '0;
            wrap  <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    // req_s has priority over load in the same cycle.
                    if (req_s) begin
                        state <= nxt;
                        data1 <= nxt;
                        data0 <= ~nxt;
                        wrap  <= (nxt == start);
                        fsm   <= VALID;
                    end else if (load) begin
                        state <= seed_g;
                        start <= seed_g;
                    end
                end
                VALID: begin
                    ack <= 1'b1;
                    fsm <= HOLD;
                end
                HOLD: begin
                    if (!req_s) begin
                        data0 <= '0;
                        data1 <= '0;
                        wrap  <= 1'b0;
                        fsm   <= RTZ;
                    end
                end
                RTZ: begin
                    ack <= 1'b0;
                    fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_hs_dualrail.sv
// Directed bench for lfsr_hs_dualrail: Fibonacci and Galois instances share stimulus.
module tb_lfsr_hs_dualrail;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       load = 1'b0;
    logic [2:0] seed_in = 3'b000;
    logic       ack0, ack1, wrap0, wrap1;
    logic [2:0] d0_0, d1_0, d0_1, d1_1;

    int total = 0;
    int bad = 0;
    int nr, nf;

    always #5 clk = ~clk;

    lfsr_hs_dualrail #(.MODE(0)) dut_fib (
        .clk(clk), .rst(rst), .req(req), .ack(ack0),
        .data0(d0_0), .data1(d1_0), .load(load), .seed_in(seed_in), .wrap(wrap0)
    );

    lfsr_hs_dualrail #(.MODE(1)) dut_gal (
        .clk(clk), .rst(rst), .req(req), .ack(ack1),
        .data0(d0_1), .data1(d1_1), .load(load), .seed_in(seed_in), .wrap(wrap1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // No bit may ever show both rails high.
    always @(negedge clk) begin
        if (!rst) begin
            chk("dualrail_fib", {29'd0, d0_0 & d1_0}, 32'd0);
            chk("dualrail_gal", {29'd0, d0_1 & d1_1}, 32'd0);
        end
    end

    // One full handshake; checks word, wrap, and the return to spacer before ack falls.
    task automatic hs(input logic [2:0] e_f, input logic w_f,
                      input logic [2:0] e_g, input logic w_g, input logic chk_g,
                      input logic ld_hold, output int rise, output int fall);
        logic [2:0] inv_f, inv_g;
        inv_f = ~e_f;
        inv_g = ~e_g;
        req = 1'b1;
        rise = 0;
        do begin
            @(posedge clk); #1;
            rise++;
        end while (!ack0 && rise < 20);
        chk("ack_rise", {31'd0, ack0}, 32'd1);
        chk("fib_data1", {29'd0, d1_0}, {29'd0, e_f});
        chk("fib_data0", {29'd0, d0_0}, {29'd0, inv_f});
        chk("fib_wrap", {31'd0, wrap0}, {31'd0, w_f});
        if (chk_g) begin
            chk("gal_data1", {29'd0, d1_1}, {29'd0, e_g});
            chk("gal_data0", {29'd0, d0_1}, {29'd0, inv_g});
            chk("gal_wrap", {31'd0, wrap1}, {31'd0, w_g});
        end
        if (ld_hold) begin
            load = 1'b1;
            seed_in = 3'b101;
            @(posedge clk); #1;
            load = 1'b0;
            seed_in = 3'b000;
        end
        req = 1'b0;
        fall = 0;
        do begin
            @(posedge clk); #1;
            fall++;
            if (fall == 3) begin
                chk("spacer_before_ackfall_ack", {31'd0, ack0}, 32'd1);
                chk("spacer_before_ackfall_rails", {26'd0, d0_0, d1_0}, 32'd0);
            end
        end while (ack0 && fall < 20);
        chk("ack_fall", {31'd0, ack0}, 32'd0);
        chk("rails_spacer", {26'd0, d0_0, d1_0}, 32'd0);
        chk("wrap_cleared", {31'd0, wrap0}, 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_ack", {31'd0, ack0}, 32'd0);
        chk("rst_rails", {26'd0, d0_0, d1_0}, 32'd0);
        chk("rst_wrap", {31'd0, wrap0}, 32'd0);
        chk("rst_gal_ack", {31'd0, ack1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Sequences from SEED 001: Fibonacci on dut_fib, Galois on dut_gal
        hs(3'b010, 0, 3'b010, 0, 1, 0, nr, nf);
        chk("lat_rise", nr, 32'd4);
        chk("lat_fall", nf, 32'd4);
        hs(3'b101, 0, 3'b100, 0, 1, 0, nr, nf);
        hs(3'b011, 0, 3'b011, 0, 1, 0, nr, nf);
        hs(3'b111, 0, 3'b110, 0, 1, 0, nr, nf);
        hs(3'b110, 0, 3'b111, 0, 1, 0, nr, nf);
        hs(3'b100, 0, 3'b101, 0, 1, 0, nr, nf);
        hs(3'b001, 1, 3'b001, 1, 1, 0, nr, nf);
        hs(3'b010, 0, 3'b010, 0, 1, 0, nr, nf);

        // Zero seed load falls back to 001; load during HOLD is ignored
        load = 1'b1;
        seed_in = 3'b000;
        @(posedge clk); #1;
        load = 1'b0;
        hs(3'b010, 0, 3'b000, 0, 0, 1, nr, nf);
        hs(3'b101, 0, 3'b000, 0, 0, 0, nr, nf);

        // Asynchronous reset while in HOLD
        req = 1'b1;
        nr = 0;
        do begin
            @(posedge clk); #1;
            nr++;
        end while (!ack0 && nr < 20);
        chk("hold_reached", {31'd0, ack0}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ack", {31'd0, ack0}, 32'd0);
        chk("async_rst_rails", {26'd0, d0_0, d1_0}, 32'd0);
        chk("async_rst_wrap", {31'd0, wrap0}, 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        hs(3'b010, 0, 3'b000, 0, 0, 0, nr, nf);

        // Short req pulse dropped before ack: exactly one step
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        nr = 1;
        while (!ack0 && nr < 20) begin
            @(posedge clk); #1;
            nr++;
        end
        chk("pulse_ack_rise", {31'd0, ack0}, 32'd1);
        chk("pulse_data1", {29'd0, d1_0}, 32'd2);
        chk("pulse_data0", {29'd0, d0_0}, 32'd5);
        nf = 0;
        while (ack0 && nf < 20) begin
            @(posedge clk); #1;
            nf++;
        end
        chk("pulse_ack_fall", {31'd0, ack0}, 32'd0);
        chk("pulse_spacer", {26'd0, d0_0, d1_0}, 32'd0);
        hs(3'b101, 0, 3'b000, 0, 0, 0, nr, nf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
